// File: rtl/exec_pkg.sv
// Shared types and select-code bit positions for the execute stage.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0, ALU_EOR, ALU_SUB, ALU_RSB,
        ALU_ADD, ALU_ADC, ALU_SBC, ALU_RSC,
        ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN,
        ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // Select fields are priority-decoded by bit, so the codes are given as bit positions
    localparam int RS_SEL_ROT_BIT     = 1;
    localparam int RS_SEL_REG_BIT     = 0;
    localparam int ALUB_SEL_BR_BIT    = 0;
    localparam int ALUB_SEL_IMM12_BIT = 1;

    function automatic logic add_overflow(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] s);
        return (x[31] == y[31]) && (s[31] != x[31]);
    endfunction

endpackage

// File: rtl/barrel_shift32.sv
// Combinational 32-bit ARM operand-2 shifter; register-specified shifts need EXEC_REG_SHIFT_EN.
module barrel_shift32
    import exec_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [7:0]  i_amount,
    input  logic        i_carry,
    input  logic [2:0]  i_shift_op,
    output logic [31:0] o_out,
    output logic        o_carry
);

    shift_type_e w_type;
    logic        w_reg_mode;
    logic [4:0]  w_n;
    logic [32:0] w_lsl;
    logic [32:0] w_lsr;
    logic [32:0] w_asr;
    logic [31:0] w_ror;

    assign w_type = shift_type_e'(i_shift_op[2:1]);
    assign w_n    = i_amount[4:0];

`ifdef EXEC_REG_SHIFT_EN
    assign w_reg_mode = i_shift_op[0];
`else
    logic w_unused;
    assign w_reg_mode = 1'b0;
    assign w_unused   = ^{i_shift_op[0], i_amount[7:5]};
`endif

    // Extra bit beside the data catches the last bit shifted out
    assign w_lsl = {1'b0, i_data} << w_n;
    assign w_lsr = {i_data, 1'b0} >> w_n;
    assign w_asr = $signed({i_data, 1'b0}) >>> w_n;
    assign w_ror = (i_data >> w_n) | (i_data << (6'd32 - {1'b0, w_n}));

    always_comb begin
        o_out   = i_data;
        o_carry = i_carry;
        if (w_reg_mode && (i_amount == 8'd0)) begin
            o_out   = i_data;
            o_carry = i_carry;
        end else if (w_reg_mode && (i_amount[7:5] != 3'd0)) begin
            case (w_type)
                SH_LSL: begin
                    o_out   = '0;
                    o_carry = (i_amount == 8'd32) & i_data[0];
                end
                SH_LSR: begin
                    o_out   = '0;
                    o_carry = (i_amount == 8'd32) & i_data[31];
                end
                SH_ASR: begin
                    o_out   = {32{i_data[31]}};
                    o_carry = i_data[31];
                end
                default: begin
                    o_out   = w_ror;
                    o_carry = (w_n == 5'd0) ? i_data[31] : w_ror[31];
                end
            endcase
        end else if (!w_reg_mode && (w_n == 5'd0)) begin
            // Immediate #0 encodes LSL #0, LSR #32, ASR #32 and RRX
            case (w_type)
                SH_LSL: begin
                    o_out   = i_data;
                    o_carry = i_carry;
                end
                SH_LSR: begin
                    o_out   = '0;
                    o_carry = i_data[31];
                end
                SH_ASR: begin
                    o_out   = {32{i_data[31]}};
                    o_carry = i_data[31];
                end
                default: begin
                    o_out   = {i_carry, i_data[31:1]};
                    o_carry = i_data[0];
                end
            endcase
        end else begin
            case (w_type)
                SH_LSL:  {o_carry, o_out} = w_lsl;
                SH_LSR:  {o_out, o_carry} = w_lsr;
                SH_ASR:  {o_out, o_carry} = w_asr;
                default: begin
                    o_out   = w_ror;
                    o_carry = w_ror[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: operand muxes, barrel shifter, 16-op ALU, F latch and NZCV flags.
// Define EXEC_REG_SHIFT_EN to enable register-specified shift semantics.
module exec_unit
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] pc,
    input  logic [4:0]  imm5,
    input  logic [11:0] imm12,
    input  logic [23:0] imm24,
    input  logic        rm_imm_s,
    input  logic [1:0]  rs_imm_s,
    input  logic [2:0]  shift_op,
    input  logic        alu_a_s,
    input  logic [1:0]  alu_b_s,
    input  logic [3:0]  alu_op,
    input  logic        s_ctrl,
    input  logic        lf,
    output logic [31:0] fout,
    output logic [31:0] f,
    output logic [3:0]  nzcv
);

    logic [31:0] r_f;
    logic [3:0]  r_nzcv;

    logic [7:0]  w_amount;
    logic [31:0] w_sh_data;
    logic [31:0] w_sh_out;
    logic        w_sh_carry;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    alu_op_e     w_op;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_cin;
    logic        w_arith;
    logic [31:0] w_logic;
    logic [32:0] w_sum;
    logic [3:0]  w_flags;
    logic        w_c_old;
    logic        w_unused_c;

    assign w_c_old    = r_nzcv[1];
    assign w_unused_c = ^c_in[31:8];

    assign w_sh_data = rm_imm_s ? {24'b0, imm12[7:0]} : b_in;

    always_comb begin
        if (rs_imm_s[RS_SEL_ROT_BIT])
            w_amount = {3'b0, imm12[11:8], 1'b0};
        else if (rs_imm_s[RS_SEL_REG_BIT])
            w_amount = c_in[7:0];
        else
            w_amount = {3'b0, imm5};
    end

    barrel_shift32 u_shift (
        .i_data     (w_sh_data),
        .i_amount   (w_amount),
        .i_carry    (w_c_old),
        .i_shift_op (shift_op),
        .o_out      (w_sh_out),
        .o_carry    (w_sh_carry)
    );

    assign w_alu_a = alu_a_s ? pc : a_in;

    always_comb begin
        if (alu_b_s[ALUB_SEL_BR_BIT])
            w_alu_b = {{6{imm24[23]}}, imm24, 2'b00};
        else if (alu_b_s[ALUB_SEL_IMM12_BIT])
            w_alu_b = {20'b0, imm12};
        else
            w_alu_b = w_sh_out;
    end

    assign w_op = alu_op_e'(alu_op);

    // Every arithmetic op is one adder: x + y + cin, with subtraction as x + ~y + cin
    always_comb begin
        w_x     = w_alu_a;
        w_y     = w_alu_b;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        w_logic = '0;
        case (w_op)
            ALU_AND, ALU_TST: w_logic = w_alu_a & w_alu_b;
            ALU_EOR, ALU_TEQ: w_logic = w_alu_a ^ w_alu_b;
            ALU_SUB, ALU_CMP: begin
                w_arith = 1'b1;
                w_y     = ~w_alu_b;
                w_cin   = 1'b1;
            end
            ALU_RSB: begin
                w_arith = 1'b1;
                w_x     = w_alu_b;
                w_y     = ~w_alu_a;
                w_cin   = 1'b1;
            end
            ALU_ADD, ALU_CMN: w_arith = 1'b1;
            ALU_ADC: begin
                w_arith = 1'b1;
                w_cin   = w_c_old;
            end
            ALU_SBC: begin
                w_arith = 1'b1;
                w_y     = ~w_alu_b;
                w_cin   = w_c_old;
            end
            ALU_RSC: begin
                w_arith = 1'b1;
                w_x     = w_alu_b;
                w_y     = ~w_alu_a;
                w_cin   = w_c_old;
            end
            ALU_ORR: w_logic = w_alu_a | w_alu_b;
            ALU_MOV: w_logic = w_alu_b;
            ALU_BIC: w_logic = w_alu_a & ~w_alu_b;
            default: w_logic = ~w_alu_b;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'b0, w_cin};
        fout  = w_arith ? w_sum[31:0] : w_logic;
        w_flags[3] = fout[31];
        w_flags[2] = (fout == 32'd0);
        w_flags[1] = w_arith ? w_sum[32] : w_sh_carry;
        w_flags[0] = w_arith ? add_overflow(w_x, w_y, w_sum[31:0]) : r_nzcv[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_f    <= '0;
            r_nzcv <= '0;
        end else begin
            if (lf)
                r_f <= fout;
            if (s_ctrl)
                r_nzcv <= w_flags;
        end
    end

    assign f    = r_f;
    assign nzcv = r_nzcv;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit; expectations adapt to EXEC_REG_SHIFT_EN.
module tb_exec_unit;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a_in, b_in, c_in, pc;
    logic [4:0]  imm5;
    logic [11:0] imm12;
    logic [23:0] imm24;
    logic        rm_imm_s;
    logic [1:0]  rs_imm_s;
    logic [2:0]  shift_op;
    logic        alu_a_s;
    logic [1:0]  alu_b_s;
    logic [3:0]  alu_op;
    logic        s_ctrl, lf;
    logic [31:0] fout, f;
    logic [3:0]  nzcv;

    exec_unit dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .c_in(c_in), .pc(pc),
        .imm5(imm5), .imm12(imm12), .imm24(imm24), .rm_imm_s(rm_imm_s),
        .rs_imm_s(rs_imm_s), .shift_op(shift_op), .alu_a_s(alu_a_s),
        .alu_b_s(alu_b_s), .alu_op(alu_op), .s_ctrl(s_ctrl), .lf(lf),
        .fout(fout), .f(f), .nzcv(nzcv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fout;
        logic [31:0] f;
        logic [3:0]  nzcv;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_f    = '0;
    logic [3:0]  exp_nzcv = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_in = '0; b_in = '0; c_in = '0; pc = '0;
        imm5 = '0; imm12 = '0; imm24 = '0;
        rm_imm_s = 1'b0; rs_imm_s = 2'b00; shift_op = 3'b000;
        alu_a_s = 1'b0; alu_b_s = 2'b00; alu_op = ALU_MOV;
        s_ctrl = 1'b0; lf = 1'b0;
    endtask

    // Inputs are already driven; queue the outcome, check fout, then the registers after the edge
    task automatic go(input string tag, input logic [31:0] e_fout, input logic [3:0] e_nzcv);
        exp_t e;
        e.fout = e_fout;
        e.f    = lf ? e_fout : exp_f;
        e.nzcv = s_ctrl ? e_nzcv : exp_nzcv;
        sb_q.push_back(e);
        #1;
        check({tag, ".fout"}, fout, sb_q[0].fout);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".f"}, f, e.f);
        check({tag, ".nzcv"}, {28'd0, nzcv}, {28'd0, e.nzcv});
        exp_f    = e.f;
        exp_nzcv = e.nzcv;
    endtask

    initial begin
        idle();
        #2;
        check("reset.f", f, 32'd0);
        check("reset.nzcv", {28'd0, nzcv}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        idle(); alu_op = ALU_ADD; a_in = 32'h7FFF_FFFF; b_in = 32'd1; s_ctrl = 1; lf = 1;
        go("add_ovf", 32'h8000_0000, 4'b1001);

        idle(); b_in = 32'h1234; lf = 1;
        go("mov_load", 32'h0000_1234, 4'b0000);

        // Asynchronous reset between edges, held across an edge with loads requested
        idle(); b_in = 32'hDEAD_BEEF; lf = 1; s_ctrl = 1;
        #2;
        rst = 1'b0;
        #1;
        check("arst.f", f, 32'd0);
        check("arst.nzcv", {28'd0, nzcv}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_hold.f", f, 32'd0);
        check("arst_hold.nzcv", {28'd0, nzcv}, 32'd0);
        exp_f = '0; exp_nzcv = '0;
        @(negedge clk);
        rst = 1'b1;

        idle(); alu_op = ALU_SUB; a_in = 5; b_in = 5; s_ctrl = 1;
        go("sub_eq", 32'd0, 4'b0110);
        idle(); alu_op = ALU_ADD; a_in = 1; b_in = 1; s_ctrl = 1; lf = 1;
        go("add_clrc", 32'd2, 4'b0000);
        idle(); alu_op = ALU_SBC; a_in = 5; b_in = 5; s_ctrl = 1; lf = 1;
        go("sbc_c0", 32'hFFFF_FFFF, 4'b1000);
        idle(); alu_op = ALU_CMP; a_in = 5; b_in = 3; s_ctrl = 1;
        go("cmp", 32'd2, 4'b0010);
        idle(); alu_op = ALU_ADC; a_in = 1; b_in = 1; s_ctrl = 1; lf = 1;
        go("adc_c1", 32'd3, 4'b0000);

        idle(); rm_imm_s = 1; rs_imm_s[RS_SEL_ROT_BIT] = 1'b1; imm12 = 12'h1FF;
        shift_op = 3'b110; s_ctrl = 1; lf = 1;
        go("imm_ror", 32'hC000_003F, 4'b1010);
        idle(); b_in = 32'd2; shift_op = 3'b110; s_ctrl = 1;
        go("rrx", 32'h8000_0001, 4'b1000);
        idle(); b_in = 32'hF000_000F; imm5 = 5'd4; shift_op = 3'b000; s_ctrl = 1;
        go("lsl4", 32'h0000_00F0, 4'b0010);
        idle(); b_in = 32'h8000_0000; shift_op = 3'b100; s_ctrl = 1;
        go("asr32", 32'hFFFF_FFFF, 4'b1010);

        idle(); b_in = 32'h8000_0000; rs_imm_s[RS_SEL_REG_BIT] = 1'b1; c_in = 32'h20;
        shift_op = 3'b011; s_ctrl = 1;
        go("lsr_r32", 32'd0, 4'b0110);
        c_in = 32'h21;
`ifdef EXEC_REG_SHIFT_EN
        go("lsr_r33", 32'd0, 4'b0100);
`else
        go("lsr_r33", 32'h4000_0000, 4'b0000);
`endif
        c_in = 32'h0;
`ifdef EXEC_REG_SHIFT_EN
        go("lsr_r0", 32'h8000_0000, 4'b1000);
`else
        go("lsr_r0", 32'd0, 4'b0110);
`endif

        idle(); alu_op = ALU_RSB; a_in = 3; b_in = 10; s_ctrl = 1; lf = 1;
        go("rsb", 32'd7, 4'b0010);
        idle(); alu_op = ALU_RSC; a_in = 3; b_in = 10; s_ctrl = 1; lf = 1;
        go("rsc_c1", 32'd7, 4'b0010);
        idle(); alu_op = ALU_ADD; a_in = 32'h7FFF_FFFF; b_in = 32'd1; s_ctrl = 1;
        go("add_setv", 32'h8000_0000, 4'b1001);
        idle(); alu_op = ALU_BIC; a_in = 32'hFF; b_in = 32'h0F; s_ctrl = 1; lf = 1;
        go("bic_keepv", 32'h0000_00F0, 4'b0001);

        idle(); alu_op = ALU_ADD; alu_a_s = 1; pc = 32'h100; alu_b_s[ALUB_SEL_BR_BIT] = 1'b1;
        imm24 = 24'hFFFFFE; lf = 1;
        go("branch", 32'h0000_00F8, 4'b0000);
        idle(); alu_op = ALU_EOR; a_in = 32'hFFF; alu_b_s[ALUB_SEL_IMM12_BIT] = 1'b1;
        imm12 = 12'hABC; s_ctrl = 1;
        go("eor_imm12", 32'h0000_0543, 4'b0001);
        idle(); alu_op = ALU_TEQ; a_in = 32'h55; b_in = 32'h55; s_ctrl = 1;
        go("teq", 32'd0, 4'b0101);
        idle(); alu_op = ALU_MVN; s_ctrl = 1; lf = 1;
        go("mvn", 32'hFFFF_FFFF, 4'b1001);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, 0 required", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
